alu_seq_unit: RTL and testbench

Parametrised, handshaked, registered successor to the combinational 128-bit ALU. It accepts one operation per valid/ready transfer and holds the result and flags in registers until the consumer takes them. It adds a sticky carry for multi-word add/sub, correct signed overflow for subtraction, and multi-cycle variable-amount shifts/rotates. It sits between the register-file read stage and writeback, and is the datapath ALU for the sequential CPU.

---
 rtl/alu_seq_unit.sv | 156 +++++++++++++++
 tb/tb_alu_seq_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - handshaked registered ALU with sticky carry and multi-cycle shifts
module alu_seq_unit #(
  parameter int DWIDTH = 32,
  parameter int SHW    = $clog2(DWIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] op1,
  input  logic [DWIDTH-1:0] op2,
  input  logic [2:0]        opsel,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] result,
  output logic              c_flag,
  output logic              z_flag,
  output logic              o_flag,
  output logic              s_flag,
  output logic              busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DWIDTH-1:0] work;
  logic [SHW-1:0]    cnt;
  logic [1:0]        sh_op;

  logic [SHW-1:0]    amt;
  logic              long_shift;
  logic [DWIDTH:0]   step;
  logic [DWIDTH-1:0] add_b;
  logic              add_cin;
  logic [DWIDTH:0]   sum;
  logic [DWIDTH-1:0] acc_res;
  logic [DWIDTH-1:0] acc_zs;
  logic              acc_c;
  logic              acc_o;

  // One-bit shift step, returned as {bit shifted out, new value}; for rol the
  // bit carried out equals the new bit 0, which is the required carry.
  function automatic logic [DWIDTH:0] shift_step(input logic [1:0] kind,
                                                 input logic [DWIDTH-1:0] v);
    case (kind)
      2'd0:    shift_step = {v[DWIDTH-1], v[DWIDTH-2:0], 1'b0};
      2'd1:    shift_step = {v[0], 1'b0, v[DWIDTH-1:1]};
      2'd2:    shift_step = {v[0], v[DWIDTH-1], v[DWIDTH-1:1]};
      default: shift_step = {v[DWIDTH-1], v[DWIDTH-2:0], v[DWIDTH-1]};
    endcase
  endfunction

  assign in_ready   = (state == IDLE) && (!out_valid || out_ready) && !rst;
  assign busy       = (state == SHIFT);
  assign amt        = op2[SHW-1:0];
  assign long_shift = mode && opsel[2] && (amt > SHW'(1));
  assign step       = shift_step(busy ? sh_op : opsel[1:0], busy ? work : op1);

  always_comb begin
    add_b   = op2;
    add_cin = 1'b0;
    case (opsel)
      3'b001, 3'b110: begin add_b = ~op2; add_cin = 1'b1; end
      3'b010:         add_cin = c_flag;
      3'b011:         begin add_b = ~op2; add_cin = c_flag; end
      3'b100:         begin add_b = '0; add_cin = 1'b1; end
      3'b101:         add_b = '1;
      default:        ;
    endcase
    sum     = {1'b0, op1} + {1'b0, add_b} + (DWIDTH+1)'(add_cin);
    acc_res = sum[DWIDTH-1:0];
    acc_zs  = sum[DWIDTH-1:0];
    acc_c   = sum[DWIDTH];
    acc_o   = (op1[DWIDTH-1] == add_b[DWIDTH-1]) && (sum[DWIDTH-1] != op1[DWIDTH-1]);
    if (!mode) begin
      // cmp keeps op1 as the result but reports the subtraction's flags
      if (opsel == 3'b110) begin
        acc_res = op1;
      end else if (opsel == 3'b111) begin
        acc_res = '0;
        acc_zs  = '0;
        acc_c   = 1'b0;
        acc_o   = 1'b0;
      end
    end else begin
      acc_c = 1'b0;
      acc_o = 1'b0;
      case (opsel)
        3'b000:  acc_res = op1 & op2;
        3'b001:  acc_res = op1 | op2;
        3'b010:  acc_res = op1 ^ op2;
        3'b011:  acc_res = ~op1;
        default: begin
          if (amt != '0) begin
            acc_res = step[DWIDTH-1:0];
            acc_c   = step[DWIDTH];
          end else begin
            acc_res = op1;
          end
        end
      endcase
      acc_zs = acc_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      o_flag    <= 1'b0;
      s_flag    <= 1'b0;
      cnt       <= '0;
      work      <= '0;
      sh_op     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            if (long_shift) begin
              work  <= step[DWIDTH-1:0];
              cnt   <= amt - SHW'(1);
              sh_op <= opsel[1:0];
              state <= SHIFT;
            end else begin
              result    <= acc_res;
              c_flag    <= acc_c;
              o_flag    <= acc_o;
              z_flag    <= (acc_zs == '0);
              s_flag    <= acc_zs[DWIDTH-1];
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= step[DWIDTH-1:0];
          cnt  <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result    <= step[DWIDTH-1:0];
            c_flag    <= step[DWIDTH];
            o_flag    <= 1'b0;
            z_flag    <= (step[DWIDTH-1:0] == '0);
            s_flag    <= step[DWIDTH-1];
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - randomized and directed bench for alu_seq_unit against an arithmetic model
module tb_alu_seq_unit;

  typedef struct packed {
    logic [2:0]  os;
    logic        md;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1, op2;
  logic [2:0]  opsel;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        c_flag, z_flag, o_flag, s_flag;
  logic        busy;

  int   n_vec = 0;
  int   n_err = 0;
  logic m_c   = 1'b0;

  op_t dir [15] = '{
    {3'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001},
    {3'd1, 1'b0, 32'h8000_0000, 32'h0000_0001},
    {3'd6, 1'b0, 32'h0000_0005, 32'h0000_0007},
    {3'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001},
    {3'd2, 1'b0, 32'h0000_0000, 32'h0000_0000},
    {3'd4, 1'b1, 32'h0000_0001, 32'd31},
    {3'd6, 1'b1, 32'h8000_0000, 32'd4},
    {3'd4, 1'b1, 32'hC000_0000, 32'd1},
    {3'd7, 1'b1, 32'h8000_0001, 32'd0},
    {3'd7, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0},
    {3'd4, 1'b0, 32'h7FFF_FFFF, 32'h0000_0000},
    {3'd5, 1'b0, 32'h0000_0000, 32'h0000_0000},
    {3'd3, 1'b0, 32'h0000_0005, 32'h0000_0007},
    {3'd7, 1'b1, 32'h8000_0001, 32'd5},
    {3'd5, 1'b1, 32'h0000_00F0, 32'd5}
  };

  alu_seq_unit #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .opsel(opsel), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag), .s_flag(s_flag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // Reference: {result, c, z, o, s} from plain integer arithmetic
  function automatic logic [35:0] model(input logic [2:0] os, input logic md,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned us;
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint          ss = 0;
    int              n  = int'(b[4:0]);
    logic [31:0]     r  = '0;
    logic [31:0]     zs;
    logic            c  = 1'b0;
    logic            o  = 1'b0;
    if (!md) begin
      case (os)
        3'd0: begin us = ua + ub; r = us[31:0]; c = us[32]; ss = sa + sb; end
        3'd1, 3'd6: begin r = a - b; c = (ua >= ub); ss = sa - sb; end
        3'd2: begin us = ua + ub + cin; r = us[31:0]; c = us[32]; ss = sa + sb + longint'(cin); end
        3'd3: begin r = a - b - 32'd1 + {31'd0, cin}; c = ((ua + cin) > ub); ss = sa - sb - 1 + longint'(cin); end
        3'd4: begin r = a + 32'd1; c = (a == 32'hFFFF_FFFF); ss = sa + 1; end
        3'd5: begin r = a - 32'd1; c = (a != 0); ss = sa - 1; end
        default: begin r = '0; ss = 0; end
      endcase
      o  = (ss != longint'($signed(ss[31:0])));
      zs = (os == 3'd6) ? (a - b) : r;
      if (os == 3'd6) r = a;
    end else begin
      case (os)
        3'd0: r = a & b;
        3'd1: r = a | b;
        3'd2: r = a ^ b;
        3'd3: r = ~a;
        3'd4: begin r = a << n; if (n != 0) c = a[32-n]; end
        3'd5: begin r = a >> n; if (n != 0) c = a[n-1]; end
        3'd6: begin r = $signed(a) >>> n; if (n != 0) c = a[n-1]; end
        default: begin r = (a << n) | (a >> (32 - n)); if (n != 0) c = r[0]; end
      endcase
      zs = r;
    end
    return {r, c, (zs == 32'd0), o, zs[31]};
  endfunction

  function automatic int model_lat(input logic [2:0] os, input logic md, input logic [31:0] b);
    if (md && os[2] && b[4:0] > 5'd1) return int'(b[4:0]);
    return 1;
  endfunction

  // Issue one op, wait for its result, then consume it
  task automatic run_op(input logic [2:0] os, input logic md, input logic [31:0] a,
                        input logic [31:0] b, output logic [35:0] got,
                        output int lat, output int bcnt);
    int w = 0;
    @(negedge clk);
    op1 = a; op2 = b; opsel = os; mode = md; in_valid = 1'b1;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    #1;
    in_valid = 1'b0; op1 = $urandom; op2 = $urandom;
    opsel = 3'($urandom_range(0, 7)); mode = 1'($urandom_range(0, 1));
    lat = 0; bcnt = 0;
    while (lat <= 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (busy && !in_ready) bcnt++;
    end
    got = {result, c_flag, z_flag, o_flag, s_flag};
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; opsel = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
    end
    n_vec++;
    if ({out_valid, busy, result, c_flag, z_flag, o_flag, s_flag} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_state: got ov=%b busy=%b res=%h czos=%b%b%b%b expected all 0",
               out_valid, busy, result, c_flag, z_flag, o_flag, s_flag);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready);
    end
    m_c = 1'b0;
  endtask

  task automatic test_directed;
    logic [35:0] got, exp;
    int lat, bcnt, elat;
    for (int i = 0; i < 15; i++) begin
      exp  = model(dir[i].os, dir[i].md, dir[i].a, dir[i].b, m_c);
      elat = model_lat(dir[i].os, dir[i].md, dir[i].b);
      run_op(dir[i].os, dir[i].md, dir[i].a, dir[i].b, got, lat, bcnt);
      m_c = exp[3];
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL directed_%0d_value: got res=%h czos=%b expected res=%h czos=%b",
                 i, got[35:4], got[3:0], exp[35:4], exp[3:0]);
      end
      n_vec++;
      if (lat !== elat || bcnt !== elat - 1) begin
        n_err++;
        $display("FAIL directed_%0d_timing: got lat=%0d busy=%0d expected lat=%0d busy=%0d",
                 i, lat, bcnt, elat, elat - 1);
      end
    end
  endtask

  task automatic test_random;
    logic [35:0] got, exp;
    logic [2:0]  os;
    logic        md;
    logic [31:0] a, b;
    int lat, bcnt, elat;
    for (int i = 0; i < 80; i++) begin
      os = 3'($urandom_range(0, 7)); md = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      if (i % 4 == 0) a = (i % 8 == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      exp  = model(os, md, a, b, m_c);
      elat = model_lat(os, md, b);
      run_op(os, md, a, b, got, lat, bcnt);
      m_c = exp[3];
      n_vec++;
      if (got !== exp || lat !== elat || bcnt !== elat - 1) begin
        n_err++;
        $display("FAIL random_%0d op=%b/%0d a=%h b=%h: got res=%h czos=%b lat=%0d busy=%0d expected res=%h czos=%b lat=%0d busy=%0d",
                 i, md, os, a, b, got[35:4], got[3:0], lat, bcnt,
                 exp[35:4], exp[3:0], elat, elat - 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [35:0] prev, exp;
    logic [2:0]  os;
    logic        md;
    @(negedge clk);
    out_ready = 1'b1;
    prev = '0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || {result, c_flag, z_flag, o_flag, s_flag} !== prev) begin
          n_err++;
          $display("FAIL b2b_%0d: got ov=%b res=%h czos=%b%b%b%b expected ov=1 res=%h czos=%b",
                   i - 1, out_valid, result, c_flag, z_flag, o_flag, s_flag,
                   prev[35:4], prev[3:0]);
        end
      end
      if (i < 10) begin
        md = 1'($urandom_range(0, 1));
        os = md ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        op1 = $urandom; op2 = $urandom; opsel = os; mode = md; in_valid = 1'b1;
        exp = model(os, md, op1, op2, m_c);
        m_c = exp[3];
        prev = exp;
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++; $display("FAIL b2b_%0d_in_ready: got %b expected 1", i, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [35:0] ea, eb;
    logic [31:0] ba, bb;
    int w = 0;
    @(negedge clk);
    ba = $urandom; bb = $urandom;
    op1 = ba; op2 = bb; opsel = 3'd0; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    ea = model(3'd0, 1'b0, ba, bb, m_c);
    m_c = ea[3];
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    #1;
    op1 = $urandom; op2 = $urandom; opsel = 3'd2; mode = 1'b1;
    eb = model(3'd2, 1'b1, op1, op2, m_c);
    m_c = eb[3];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {result, c_flag, z_flag, o_flag, s_flag} !== ea) begin
        n_err++;
        $display("FAIL backpressure_hold_%0d: got ov=%b rdy=%b res=%h czos=%b%b%b%b expected ov=1 rdy=0 res=%h czos=%b",
                 k, out_valid, in_ready, result, c_flag, z_flag, o_flag, s_flag,
                 ea[35:4], ea[3:0]);
      end
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL backpressure_release_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || {result, c_flag, z_flag, o_flag, s_flag} !== eb) begin
      n_err++;
      $display("FAIL backpressure_next: got ov=%b res=%h czos=%b%b%b%b expected ov=1 res=%h czos=%b",
               out_valid, result, c_flag, z_flag, o_flag, s_flag, eb[35:4], eb[3:0]);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL backpressure_drain: got ov=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_shift;
    logic [35:0] got, exp;
    int lat, bcnt, seen, w = 0;
    @(negedge clk);
    op1 = $urandom; op2 = 32'd20; opsel = 3'd5; mode = 1'b1; in_valid = 1'b1;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({out_valid, busy, result, c_flag, z_flag, o_flag, s_flag, in_ready} !== {38'd0, 1'b1}) begin
      n_err++;
      $display("FAIL abort_state: got ov=%b busy=%b res=%h czos=%b%b%b%b rdy=%b expected 0/0/0/0000/1",
               out_valid, busy, result, c_flag, z_flag, o_flag, s_flag, in_ready);
    end
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++; $display("FAIL abort_no_stale: got %0d valid cycles expected 0", seen);
    end
    m_c = 1'b0;
    exp = model(3'd2, 1'b0, 32'd0, 32'd0, m_c);
    run_op(3'd2, 1'b0, 32'd0, 32'd0, got, lat, bcnt);
    m_c = exp[3];
    n_vec++;
    if (got !== exp || lat !== 1) begin
      n_err++;
      $display("FAIL adc_after_reset: got res=%h czos=%b lat=%0d expected res=%h czos=%b lat=1",
               got[35:4], got[3:0], lat, exp[35:4], exp[3:0]);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_shift;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
